fetch_ctrl: RTL and testbench

Sequencer for the instruction-fetch path. It owns the single instruction-memory port and shares it between two users: a program loader that streams words into memory, and the PC-driven fetch. Once loading finishes, it runs the PC with priority redirect/stall control, detects a halt instruction, and presents fetched instructions to decode.

---
 rtl/fetch_ctrl_if.sv | 33 +++
 rtl/fetch_ctrl.sv | 97 +++++++++
 tb/tb_fetch_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch controller loader, memory-port and decode-side signal bundle
interface fetch_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              load_valid;
    logic [15:0]       load_data;
    logic              load_last;
    logic              load_ready;
    logic              stall;
    logic              redirect;
    logic [15:0]       redirect_pc;
    logic [15:0]       mem_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       pc;
    logic [15:0]       inst;
    logic              inst_valid;
    logic              halted;
    logic [15:0]       issue_cnt;
    logic [1:0]        state;

    modport master (
        input  start, load_valid, load_data, load_last, stall, redirect, redirect_pc, mem_rdata,
        output load_ready, mem_we, mem_addr, mem_wdata, pc, inst, inst_valid, halted, issue_cnt, state
    );

    modport slave (
        output start, load_valid, load_data, load_last, stall, redirect, redirect_pc, mem_rdata,
        input  load_ready, mem_we, mem_addr, mem_wdata, pc, inst, inst_valid, halted, issue_cnt, state
    );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer sharing one memory port between loader and PC fetch
module fetch_ctrl #(
    parameter int          ADDR_W    = 8,
    parameter logic [15:0] HALT_INST = 16'hFFFF
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE = 1;

    state_t            state_q;
    logic [15:0]       pc_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [15:0]       issue_q;
    logic              halted_q;

    logic in_load;
    logic in_run;
    logic xfer;
    logic issue;
    logic halt_hit;

    assign in_load  = (state_q == LOAD);
    assign in_run   = (state_q == RUN);
    assign xfer     = in_load && bus.load_valid;
    assign issue    = in_run && !bus.stall;
    // A redirect in the same cycle as the halt word overrides the halt.
    assign halt_hit = issue && (bus.mem_rdata == HALT_INST) && !bus.redirect;

    assign bus.load_ready = in_load;
    assign bus.mem_we     = xfer;
    assign bus.mem_addr   = in_load ? ptr_q : pc_q[ADDR_W-1:0];
    assign bus.mem_wdata  = xfer ? bus.load_data : 16'h0000;
    assign bus.inst       = in_run ? bus.mem_rdata : 16'h0000;
    assign bus.inst_valid = issue;
    assign bus.pc         = pc_q;
    assign bus.issue_cnt  = issue_q;
    assign bus.halted     = halted_q;
    assign bus.state      = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= 16'h0000;
            ptr_q    <= '0;
            issue_q  <= 16'h0000;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, HALT: begin
                    if (bus.load_valid) begin
                        state_q  <= LOAD;
                        ptr_q    <= '0;
                        halted_q <= 1'b0;
                    end else if (bus.start) begin
                        state_q  <= RUN;
                        pc_q     <= 16'h0000;
                        issue_q  <= 16'h0000;
                        halted_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        if (bus.load_last) begin
                            state_q <= IDLE;
                            ptr_q   <= '0;
                        end else begin
                            ptr_q <= ptr_q + PTR_ONE;
                        end
                    end
                end
                RUN: begin
                    if (issue && issue_q != 16'hFFFF) begin
                        issue_q <= issue_q + 16'd1;
                    end
                    if (bus.redirect) begin
                        pc_q <= bus.redirect_pc;
                    end else if (halt_hit) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else if (!bus.stall) begin
                        pc_q <= pc_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl against a behavioural model
module tb_fetch_ctrl;
    localparam int AW = 8;
    localparam int DEPTH = 256;
    localparam logic [15:0] HALT_W = 16'hFFFF;
    localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_HALT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.ADDR_W(AW)) bus ();
    fetch_ctrl #(.ADDR_W(AW), .HALT_INST(HALT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [15:0] mem [DEPTH];
    logic [15:0] ref_mem [DEPTH];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain variables updated from the rules on each clock.
    int          m_st;
    int          m_ptr;
    logic [15:0] m_pc;
    logic [15:0] m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = S_IDLE; m_pc = 0; m_ptr = 0; m_cnt = 0;
        end else if (m_st == S_IDLE || m_st == S_HALT) begin
            if (bus.load_valid) begin
                m_st = S_LOAD; m_ptr = 0;
            end else if (bus.start) begin
                m_st = S_RUN; m_pc = 0; m_cnt = 0;
            end
        end else if (m_st == S_LOAD) begin
            if (bus.load_valid) begin
                ref_mem[m_ptr] = bus.load_data;
                m_ptr = (m_ptr + 1) % DEPTH;
                if (bus.load_last) begin
                    m_st = S_IDLE; m_ptr = 0;
                end
            end
        end else begin
            if (!bus.stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
            if (bus.redirect) m_pc = bus.redirect_pc;
            else if (!bus.stall && ref_mem[m_pc % DEPTH] == HALT_W) m_st = S_HALT;
            else if (!bus.stall) m_pc = 16'((32'(m_pc) + 1) % 65536);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("state", 32'(bus.state), 32'(m_st));
            chk("pc", 32'(bus.pc), 32'(m_pc));
            chk("issue_cnt", 32'(bus.issue_cnt), 32'(m_cnt));
            chk("halted", 32'(bus.halted), 32'(m_st == S_HALT));
            chk("load_ready", 32'(bus.load_ready), 32'(m_st == S_LOAD));
            chk("mem_we", 32'(bus.mem_we), 32'(m_st == S_LOAD && bus.load_valid));
            chk("inst_valid", 32'(bus.inst_valid), 32'(m_st == S_RUN && !bus.stall));
            chk("inst", 32'(bus.inst), (m_st == S_RUN) ? 32'(ref_mem[m_pc % DEPTH]) : 32'h0);
            if (m_st == S_LOAD && bus.load_valid) begin
                chk("mem_addr_wr", 32'(bus.mem_addr), 32'(m_ptr));
                chk("mem_wdata_wr", 32'(bus.mem_wdata), 32'(bus.load_data));
            end else begin
                chk("mem_wdata_idle", 32'(bus.mem_wdata), 32'h0);
            end
            if (m_st == S_RUN) chk("mem_addr_run", 32'(bus.mem_addr), 32'(m_pc % DEPTH));
        end
    end

    logic [15:0] prog [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start = 0; bus.load_valid = 0; bus.load_data = 0; bus.load_last = 0;
        bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic do_load(input bit gaps);
        bus.load_valid = 1; bus.load_data = prog[0]; bus.load_last = 0;
        tick();
        for (int i = 0; i < prog.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.load_valid = 0;
                tick();
            end
            bus.load_valid = 1; bus.load_data = prog[i]; bus.load_last = (i == prog.size() - 1);
            tick();
        end
        bus.load_valid = 0; bus.load_last = 0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin mem[i] = 0; ref_mem[i] = 0; end
        clear_inputs();
        #2;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_pc", 32'(bus.pc), 0);
        chk("rst_cnt", 32'(bus.issue_cnt), 0);
        chk("rst_halted", 32'(bus.halted), 0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_load_ready", 32'(bus.load_ready), 0);
        tick();
        rst = 0;

        // Load 1,2,3,HALT then run to halt.
        prog = '{16'h0001, 16'h0002, 16'h0003, HALT_W};
        bus.load_valid = 1; bus.load_data = prog[0];
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.load_data = prog[i]; bus.load_last = (i == 3);
            @(negedge clk);
            chk("ld_we", 32'(bus.mem_we), 1);
            chk("ld_addr", 32'(bus.mem_addr), 32'(i));
            chk("ld_data", 32'(bus.mem_wdata), 32'(prog[i]));
            chk("ld_ready", 32'(bus.load_ready), 1);
            tick();
        end
        bus.load_valid = 0; bus.load_last = 0;
        @(negedge clk);
        chk("ld_done_state", 32'(bus.state), 0);
        tick();
        bus.start = 1;
        tick();
        bus.start = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("run_pc", 32'(bus.pc), 32'(i));
            chk("run_inst", 32'(bus.inst), 32'(prog[i]));
            tick();
        end
        @(negedge clk);
        chk("halt_state", 32'(bus.state), 3);
        chk("halt_flag", 32'(bus.halted), 1);
        chk("halt_pc", 32'(bus.pc), 3);
        chk("halt_cnt", 32'(bus.issue_cnt), 4);
        tick();

        // Stall / redirect priority at pc=5.
        do_reset();
        prog.delete();
        for (int i = 0; i < 8; i++) prog.push_back(16'h0100 + 16'(i));
        do_load(0);
        bus.start = 1; tick(); bus.start = 0;
        repeat (5) tick();
        chk("st_pc5", 32'(bus.pc), 5);
        bus.stall = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("st_iv", 32'(bus.inst_valid), 0);
            tick();
            chk("st_hold", 32'(bus.pc), 5);
        end
        bus.redirect = 1; bus.redirect_pc = 16'h0040;
        tick();
        clear_inputs();
        chk("st_redir", 32'(bus.pc), 32'h40);

        // Halt word at pc=2 with a simultaneous redirect.
        do_reset();
        prog = '{16'h0011, 16'h0022, HALT_W, 16'h0033, 16'h0044, 16'h0055, 16'h0066, 16'h0077, 16'h0088};
        do_load(1);
        bus.start = 1; tick(); bus.start = 0;
        repeat (2) tick();
        bus.redirect = 1; bus.redirect_pc = 16'h0008;
        @(negedge clk);
        chk("hs_inst", 32'(bus.inst), 32'hFFFF);
        tick();
        bus.redirect = 0;
        chk("hs_state", 32'(bus.state), 2);
        chk("hs_pc", 32'(bus.pc), 8);
        tick();

        // 257-word load wraps onto address 0; PC wraps from FFFF.
        do_reset();
        prog.delete();
        for (int i = 0; i < 256; i++) prog.push_back(16'($urandom) & 16'h7FFF);
        prog.push_back(16'h0ABC);
        do_load(0);
        tick();
        chk("wrap_mem0", 32'(mem[0]), 32'h0ABC);
        chk("wrap_mem255", 32'(mem[255]), 32'(prog[255]));
        bus.start = 1; tick(); bus.start = 0;
        bus.redirect = 1; bus.redirect_pc = 16'hFFFF;
        tick();
        bus.redirect = 0;
        chk("wrap_pc_ffff", 32'(bus.pc), 32'hFFFF);
        tick();
        chk("wrap_pc_0", 32'(bus.pc), 0);

        // Asynchronous reset after three loaded words.
        do_reset();
        bus.load_valid = 1; bus.load_data = 16'h00A0;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.load_data = 16'h00A0 + 16'(i);
            tick();
        end
        chk("ar_pre_state", 32'(bus.state), 1);
        #2;
        rst = 1;
        bus.load_valid = 0;
        #1;
        chk("ar_state", 32'(bus.state), 0);
        chk("ar_ready", 32'(bus.load_ready), 0);
        chk("ar_pc", 32'(bus.pc), 0);
        tick();
        rst = 0;
        for (int i = 0; i < 3; i++) chk("ar_mem", 32'(mem[i]), 32'h00A0 + 32'(i));
        bus.load_valid = 1; bus.load_data = 16'hBEEF; bus.load_last = 1;
        tick();
        @(negedge clk);
        chk("ar_reload_addr", 32'(bus.mem_addr), 0);
        tick();
        clear_inputs();
        chk("ar_reload_mem", 32'(mem[0]), 32'hBEEF);

        // Randomised programs followed by unconstrained input traffic.
        for (int it = 0; it < 20; it++) begin
            do_reset();
            prog.delete();
            for (int i = 0; i < $urandom_range(3, 12); i++)
                prog.push_back(($urandom_range(0, 5) == 0) ? HALT_W : 16'($urandom));
            do_load(1);
            bus.start = 1; tick();
            for (int c = 0; c < 40; c++) begin
                bus.start = ($urandom_range(0, 7) == 0);
                bus.stall = ($urandom_range(0, 3) == 0);
                bus.redirect = ($urandom_range(0, 7) == 0);
                bus.redirect_pc = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
                bus.load_valid = ($urandom_range(0, 9) == 0);
                bus.load_data = ($urandom_range(0, 3) == 0) ? HALT_W : 16'($urandom);
                bus.load_last = ($urandom_range(0, 3) == 0);
                tick();
            end
        end
        clear_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
